// File: rtl/systolic_a_feeder.sv
// systolic_a_feeder: buffers a DIM x DIM tile of A operands and streams it
// into the array row inputs with a per-lane diagonal skew (lane i delayed i).
module systolic_a_feeder #(
    parameter int BITS_AB = 8,
    parameter int DIM     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(DIM)-1:0]     wr_row,
    input  logic [DIM*BITS_AB-1:0]     wr_data,
    input  logic                       start,
    input  logic                       stall,
    output logic                       busy,
    output logic                       done,
    output logic [DIM*BITS_AB-1:0]     a_out,
    output logic [DIM-1:0]             a_valid
);

    localparam int TW = $clog2(2*DIM);
    localparam logic [TW-1:0] T_LAST = TW'(2*DIM-2);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                 state_q;
    logic [TW-1:0]          t_q;
    logic [TW-1:0]          t_d;
    logic [BITS_AB-1:0]     tile_q [DIM][DIM];
    logic                   busy_q;
    logic                   done_q;
    logic [DIM*BITS_AB-1:0] a_out_q;
    logic [DIM*BITS_AB-1:0] a_out_d;
    logic [DIM-1:0]         a_valid_q;
    logic [DIM-1:0]         a_valid_d;
    logic                   wr_ok;

    // Rows can only be loaded while idle; a simultaneous start wins.
    assign wr_ok = (state_q == IDLE) && wr_en && !start
                   && (int'(wr_row) < DIM);

    // Next step index and the skewed lane values that step presents.
    always_comb begin
        t_d       = (state_q == IDLE) ? '0 : t_q + 1'b1;
        a_out_d   = '0;
        a_valid_d = '0;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                if (int'(t_d) - i == j) begin
                    a_out_d[i*BITS_AB +: BITS_AB] = tile_q[i][j];
                    a_valid_d[i] = 1'b1;
                end
            end
        end
    end

    // Control FSM, tile storage and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            t_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            a_out_q   <= '0;
            a_valid_q <= '0;
            for (int i = 0; i < DIM; i++) begin
                for (int j = 0; j < DIM; j++) begin
                    tile_q[i][j] <= '0;
                end
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= STREAM;
                        t_q       <= t_d;
                        busy_q    <= 1'b1;
                        a_out_q   <= a_out_d;
                        a_valid_q <= a_valid_d;
                    end else if (wr_ok) begin
                        for (int j = 0; j < DIM; j++) begin
                            tile_q[wr_row][j] <= wr_data[j*BITS_AB +: BITS_AB];
                        end
                    end
                end
                STREAM: begin
                    if (!stall) begin
                        if (t_q == T_LAST) begin
                            state_q   <= IDLE;
                            t_q       <= '0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            a_out_q   <= '0;
                            a_valid_q <= '0;
                        end else begin
                            t_q       <= t_d;
                            a_out_q   <= a_out_d;
                            a_valid_q <= a_valid_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign a_out   = a_out_q;
    assign a_valid = a_valid_q;

endmodule

// File: doc/systolic_a_feeder.md
Name: systolic_a_feeder

Overview:
- Transmit-side companion to the tpumac array.
- Buffers a DIM x DIM tile of signed 8-bit A operands, written one row per cycle.
- On start, streams the tile into the array's row inputs with the diagonal skew the MAC chain requires: lane i is delayed i cycles.
- Sits between the host/MMIO write path and the Ain inputs of the leftmost tpumac column.

Parameters:
- BITS_AB, 8: width of each signed A element.
- DIM, 8: array dimension; sets the number of lanes and the tile rows/cols. Must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write one tile row this cycle.
- wr_row  input  $clog2(DIM)  row index for the write.
- wr_data  input  DIM*BITS_AB  row contents; element j in bits [j*BITS_AB +: BITS_AB].
- start  input  1  request to stream the buffered tile.
- stall  input  1  freeze streaming for this cycle.
- busy  output  1  streaming in progress.
- done  output  1  one-cycle pulse when streaming completes.
- a_out  output  DIM*BITS_AB  lane i drives array row i Ain, in bits [i*BITS_AB +: BITS_AB].
- a_valid  output  DIM  per-lane valid; doubles as the tpumac en for that row.

Behaviour:
- Reset (async, rst_n low):
  - All tile entries cleared to 0.
  - State = IDLE, step counter t = 0.
  - busy = 0, done = 0, a_out = 0, a_valid = 0.
  - Applies at any point, including mid-stream; the stream is abandoned and no done pulse is issued.
- States: IDLE, STREAM. All outputs are registered.
- IDLE:
  - wr_en=1 writes wr_data into tile row wr_row at the rising edge.
  - A wr_row >= DIM is ignored.
  - Outputs hold 0; a_valid = 0.
- IDLE -> STREAM, on the edge with start=1:
  - t = 0; busy = 1.
  - Lane outputs for t=0 are registered on that same edge.
- Lane rule at step t:
  - a_out lane i = A[i][t-i] and a_valid[i] = 1 when 0 <= t-i < DIM.
  - Otherwise lane i = 0 and a_valid[i] = 0.
  - Element values pass through unchanged; no sign or width change.
- Stream length: t runs 0 .. 2*DIM-2, i.e. 2*DIM-1 output cycles.
- Stall: stall=1 in STREAM holds t, a_out, a_valid and busy unchanged at that edge. stall is ignored in IDLE.
- STREAM -> IDLE, on the first non-stalled edge after t = 2*DIM-2:
  - a_out = 0, a_valid = 0, busy = 0.
  - done = 1 for exactly one cycle.
- Conflicts:
  - start while busy: ignored.
  - wr_en while busy: ignored; the tile is unchanged, so the stream always sees the snapshot taken at start.
  - wr_en and start in the same IDLE cycle: start wins and the write is dropped.
  - start in the cycle done is high (state is IDLE): accepted, so back-to-back tiles are allowed.
- Latency: start edge to first valid lane 0 output = 0 cycles after the edge. Last lane DIM-1 output = 2*DIM-2 cycles after it, plus any stall cycles.

Test Plan:
- DIM=4:
  - Stimulus: write rows 0..3 with A[i][j] = 16*i + j, then pulse start, no stall.
  - Required at t=0: lane0=0x00 valid, lanes1-3 invalid/0.
  - Required at t=3: lane0=0x03, lane1=0x12, lane2=0x21, lane3=0x30, all valid.
  - Required at t=6: only lane3=0x33 valid.
  - done pulses at the next edge; busy is high for exactly 7 cycles.
- Signed pass-through: A[2][1] = -128 (0x80) and A[1][3] = -1 (0xFF) appear bit-exact at t=3 on lane 2 and t=4 on lane 1.
- Stall:
  - Assert stall for 2 cycles at t=2.
  - Required: outputs frozen at the t=2 values for those 2 extra cycles, then resume.
  - Total busy = 9 cycles; done occurs 2 cycles later than in the unstalled case.
- Write during busy:
  - Write row 0 = all 0x7F at t=1.
  - Required: lane0 still emits the original values; after done, a new start streams 0x7F on lane0 for t=0..3.
- Collisions:
  - start together with wr_en (row 1 = 0x55): write dropped, stream uses the old row 1.
  - start asserted in the done cycle: the new stream begins immediately, with busy re-asserting in the next cycle.
- Reset mid-stream:
  - Drop rst_n at t=3.
  - Required: all outputs 0 asynchronously, no done pulse, tile cleared.
  - A following start streams all-zero data for 7 cycles with valid lanes asserted per the skew rule.
